// File: rtl/cluster_rate_monitor.sv
// cluster_rate_monitor
// Sequencer and supervisor for the cluster counter pipeline. After a start it
// waits PIPE_LATENCY clocks so that the counter pipeline can flush. It then
// accumulates the sum, the maximum and the number of overflow cycles of cnt_i
// over a programmable window, and publishes the results with a one-cycle done
// pulse. A hysteretic throttle flag is re-evaluated at every publish.
//
// Ports:
//   clock, reset           fabric clock, synchronous active-high reset
//   cnt_i, overflow_i      per-clock count and overflow flag from the counter
//   start_i, abort_i       begin a measurement / cancel without publishing
//   continuous_i           repeat windows back-to-back
//   window_len_i           window length in clocks (0 is treated as 1)
//   thresh_hi_i/lo_i       throttle set / clear thresholds
//   busy_o, done_o         measurement in progress / results published
//   sum_o, max_o, ovf_cnt_o  published window results
//   throttle_o             hysteretic throttle flag

module cluster_rate_monitor #(
  parameter int unsigned PIPE_LATENCY = 10,
  parameter int unsigned SUM_WIDTH    = 27,
  parameter int unsigned OVF_WIDTH    = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [10:0]          cnt_i,
  input  logic                 overflow_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic                 continuous_i,
  input  logic [15:0]          window_len_i,
  input  logic [SUM_WIDTH-1:0] thresh_hi_i,
  input  logic [SUM_WIDTH-1:0] thresh_lo_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [SUM_WIDTH-1:0] sum_o,
  output logic [10:0]          max_o,
  output logic [OVF_WIDTH-1:0] ovf_cnt_o,
  output logic                 throttle_o
);

  // Wide enough to hold PIPE_LATENCY, including the degenerate value 0.
  localparam int unsigned FlushW = $clog2(PIPE_LATENCY + 2);

  typedef enum logic [1:0] {StIdle, StFlush, StAccum} state_e;

  state_e               state_q;
  logic [FlushW-1:0]    flush_q;
  logic [15:0]          rem_q;    // samples left in the current window
  logic                 first_q;  // next ACCUM sample loads instead of adding
  logic [SUM_WIDTH-1:0] sum_q;
  logic [10:0]          max_q;
  logic [OVF_WIDTH-1:0] ovf_q;

  logic [SUM_WIDTH-1:0] sum_next;
  logic [10:0]          max_next;
  logic [OVF_WIDTH-1:0] ovf_next;
  logic [15:0]          len_eff;
  logic                 last_sample;

  always_comb begin
    sum_next = first_q ? {{(SUM_WIDTH-11){1'b0}}, cnt_i}
                       : sum_q + {{(SUM_WIDTH-11){1'b0}}, cnt_i};
    max_next = (first_q || (cnt_i > max_q)) ? cnt_i : max_q;
    if (first_q) begin
      ovf_next = {{(OVF_WIDTH-1){1'b0}}, overflow_i};
    end else if (overflow_i && !(&ovf_q)) begin
      ovf_next = ovf_q + OVF_WIDTH'(1);
    end else begin
      ovf_next = ovf_q;
    end
    len_eff     = (window_len_i == 16'd0) ? 16'd1 : window_len_i;
    last_sample = (rem_q == 16'd1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      flush_q    <= '0;
      rem_q      <= '0;
      first_q    <= 1'b1;
      sum_q      <= '0;
      max_q      <= '0;
      ovf_q      <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      sum_o      <= '0;
      max_o      <= '0;
      ovf_cnt_o  <= '0;
      throttle_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (abort_i) begin
        // Published results and the throttle flag are left untouched.
        state_q <= StIdle;
        busy_o  <= 1'b0;
        flush_q <= '0;
        rem_q   <= '0;
        first_q <= 1'b1;
        sum_q   <= '0;
        max_q   <= '0;
        ovf_q   <= '0;
      end else begin
        case (state_q)
          StIdle: begin
            if (start_i) begin
              rem_q   <= len_eff;
              first_q <= 1'b1;
              busy_o  <= 1'b1;
              if (PIPE_LATENCY == 0) begin
                state_q <= StAccum;
              end else begin
                flush_q <= FlushW'(PIPE_LATENCY);
                state_q <= StFlush;
              end
            end
          end
          StFlush: begin
            flush_q <= flush_q - FlushW'(1);
            if (flush_q == FlushW'(1)) state_q <= StAccum;
          end
          StAccum: begin
            sum_q   <= sum_next;
            max_q   <= max_next;
            ovf_q   <= ovf_next;
            first_q <= 1'b0;
            rem_q   <= rem_q - 16'd1;
            if (last_sample) begin
              sum_o     <= sum_next;
              max_o     <= max_next;
              ovf_cnt_o <= ovf_next;
              done_o    <= 1'b1;
              // Set is checked first so it wins when thresh_lo_i > thresh_hi_i.
              if (sum_next > thresh_hi_i) begin
                throttle_o <= 1'b1;
              end else if (sum_next < thresh_lo_i) begin
                throttle_o <= 1'b0;
              end
              first_q <= 1'b1;
              if (continuous_i) begin
                rem_q <= len_eff;
              end else begin
                state_q <= StIdle;
                busy_o  <= 1'b0;
              end
            end
          end
          default: begin
            state_q <= StIdle;
            busy_o  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cluster_rate_monitor.sv
// Directed self-checking bench for cluster_rate_monitor.
module tb_cluster_rate_monitor;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] cnt_i = '0;
  logic        overflow_i = 1'b0;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic        continuous_i = 1'b0;
  logic [15:0] window_len_i = '0;
  logic [26:0] thresh_hi_i = 27'd100;
  logic [26:0] thresh_lo_i = 27'd50;
  logic        busy_o;
  logic        done_o;
  logic [26:0] sum_o;
  logic [10:0] max_o;
  logic [15:0] ovf_cnt_o;
  logic        throttle_o;

  int n_checks = 0;
  int n_fail   = 0;
  int busy_cnt;

  cluster_rate_monitor #(
    .PIPE_LATENCY(10),
    .SUM_WIDTH   (27),
    .OVF_WIDTH   (16)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .cnt_i       (cnt_i),
    .overflow_i  (overflow_i),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .continuous_i(continuous_i),
    .window_len_i(window_len_i),
    .thresh_hi_i (thresh_hi_i),
    .thresh_lo_i (thresh_lo_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .sum_o       (sum_o),
    .max_o       (max_o),
    .ovf_cnt_o   (ovf_cnt_o),
    .throttle_o  (throttle_o)
  );

  always #5 clock = ~clock;

  // Advance one clock; sample and drive 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input logic [15:0] len);
    window_len_i = len;
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
  endtask

  // Full single window with constant count: start, flush, len samples.
  task automatic run_win(input logic [15:0] len, input logic [10:0] c);
    pulse_start(len);
    cnt_i = c;
    repeat (10 + ((len == 16'd0) ? 1 : int'(len))) cyc();
  endtask

  initial begin
    repeat (2) cyc();
    reset = 1'b0;
    chk("reset_busy", 32'(busy_o), 32'd0);
    chk("reset_done", 32'(done_o), 32'd0);
    chk("reset_sum", 32'(sum_o), 32'd0);
    chk("reset_thr", 32'(throttle_o), 32'd0);

    // Basic window: ramp k on the k-th clock after start; samples 11..14.
    pulse_start(16'd4);
    busy_cnt = 0;
    for (int k = 1; k <= 14; k++) begin
      if (busy_o) busy_cnt++;
      cnt_i = 11'(k);
      cyc();
    end
    chk("basic_busy_len", 32'(busy_cnt), 32'd14);
    chk("basic_busy_end", 32'(busy_o), 32'd0);
    chk("basic_done", 32'(done_o), 32'd1);
    chk("basic_sum", 32'(sum_o), 32'd50);
    chk("basic_max", 32'(max_o), 32'd14);
    chk("basic_ovf", 32'(ovf_cnt_o), 32'd0);
    chk("basic_thr_hold", 32'(throttle_o), 32'd0);
    cyc();
    chk("basic_done_once", 32'(done_o), 32'd0);
    chk("basic_sum_held", 32'(sum_o), 32'd50);

    // Overflow count; overflow during flush must be ignored.
    pulse_start(16'd8);
    overflow_i = 1'b1;
    repeat (10) cyc();
    for (int i = 0; i < 8; i++) begin
      overflow_i = (i == 0 || i == 3 || i == 7);
      cnt_i = 11'(i);
      cyc();
    end
    overflow_i = 1'b0;
    chk("ovf_done", 32'(done_o), 32'd1);
    chk("ovf_cnt", 32'(ovf_cnt_o), 32'd3);
    chk("ovf_sum", 32'(sum_o), 32'd28);
    chk("ovf_max", 32'(max_o), 32'd7);

    // Longest window, overflow held high, largest count.
    overflow_i = 1'b1;
    run_win(16'd65535, 11'd2047);
    overflow_i = 1'b0;
    chk("sat_done", 32'(done_o), 32'd1);
    chk("sat_ovf", 32'(ovf_cnt_o), 32'd65535);
    chk("sat_sum", 32'(sum_o), 32'd134150145);
    chk("sat_max", 32'(max_o), 32'd2047);
    chk("sat_thr", 32'(throttle_o), 32'd1);

    // Continuous, gapless windows.
    continuous_i = 1'b1;
    pulse_start(16'd2);
    cnt_i = 11'd5;
    repeat (10) cyc();
    cyc();
    chk("cont_w1_mid", 32'(done_o), 32'd0);
    cyc();
    chk("cont_w1_done", 32'(done_o), 32'd1);
    chk("cont_w1_sum", 32'(sum_o), 32'd10);
    chk("cont_w1_max", 32'(max_o), 32'd5);
    chk("cont_w1_thr", 32'(throttle_o), 32'd0);
    cyc();
    chk("cont_w2_mid", 32'(done_o), 32'd0);
    cyc();
    chk("cont_w2_done", 32'(done_o), 32'd1);
    window_len_i = 16'd3;
    cyc();
    cyc();
    chk("cont_w3_done", 32'(done_o), 32'd1);
    chk("cont_w3_sum", 32'(sum_o), 32'd10);
    cyc();
    chk("cont_w4_a", 32'(done_o), 32'd0);
    cyc();
    chk("cont_w4_b", 32'(done_o), 32'd0);
    chk("cont_w4_busy", 32'(busy_o), 32'd1);
    cyc();
    chk("cont_w4_done", 32'(done_o), 32'd1);
    chk("cont_w4_sum", 32'(sum_o), 32'd15);
    continuous_i = 1'b0;
    repeat (3) cyc();
    chk("cont_stop_done", 32'(done_o), 32'd1);
    chk("cont_stop_busy", 32'(busy_o), 32'd0);

    // Abort on the last sample: nothing published.
    pulse_start(16'd4);
    cnt_i = 11'd7;
    repeat (13) cyc();
    abort_i = 1'b1;
    cyc();
    abort_i = 1'b0;
    chk("abort_done", 32'(done_o), 32'd0);
    chk("abort_busy", 32'(busy_o), 32'd0);
    chk("abort_sum_held", 32'(sum_o), 32'd15);
    chk("abort_max_held", 32'(max_o), 32'd5);
    cyc();
    chk("abort_no_late_done", 32'(done_o), 32'd0);

    // Start with abort high stays idle.
    start_i = 1'b1;
    abort_i = 1'b1;
    cyc();
    start_i = 1'b0;
    abort_i = 1'b0;
    chk("start_abort_busy", 32'(busy_o), 32'd0);

    // Window length 0 is a single sample.
    run_win(16'd0, 11'd9);
    chk("len0_done", 32'(done_o), 32'd1);
    chk("len0_sum", 32'(sum_o), 32'd9);
    chk("len0_busy", 32'(busy_o), 32'd0);

    // Throttle hysteresis: sums 120, 80, 40, 80 with hi=100, lo=50.
    run_win(16'd4, 11'd30);
    chk("thr_120", 32'(throttle_o), 32'd1);
    run_win(16'd4, 11'd20);
    chk("thr_80_hold", 32'(throttle_o), 32'd1);
    run_win(16'd4, 11'd10);
    chk("thr_40", 32'(throttle_o), 32'd0);
    run_win(16'd4, 11'd20);
    chk("thr_80_low", 32'(throttle_o), 32'd0);
    chk("thr_sum", 32'(sum_o), 32'd80);

    // Reset in the middle of ACCUM, with throttle set beforehand.
    run_win(16'd4, 11'd30);
    pulse_start(16'd4);
    cnt_i = 11'd3;
    repeat (12) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_sum", 32'(sum_o), 32'd0);
    chk("rst_max", 32'(max_o), 32'd0);
    chk("rst_thr", 32'(throttle_o), 32'd0);
    run_win(16'd2, 11'd6);
    chk("post_rst_done", 32'(done_o), 32'd1);
    chk("post_rst_sum", 32'(sum_o), 32'd12);
    chk("post_rst_max", 32'(max_o), 32'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cluster_rate_monitor.md
Name: cluster_rate_monitor

Overview:
- Sequencer and supervisor for the 768-strip cluster counter pipeline.
- Aligns a measurement window to the counter's fixed pipeline latency.
- Over a programmable window it accumulates the per-clock cluster count, max count and overflow occurrences, then publishes the results.
- Drives a hysteretic throttle flag consumed by the cluster packer to limit readout when occupancy is high.

Parameters:
- PIPE_LATENCY, 10, clocks from vpfs presented to the counter until the corresponding cnt_i/overflow_i appear; also the FLUSH duration.
- SUM_WIDTH, 27, accumulator width; sized so 1536 x 65535 cannot wrap.
- OVF_WIDTH, 16, width of the overflow-occurrence counter.

Ports:
- clock  in  1  fabric clock
- reset  in  1  synchronous, active-high
- cnt_i  in  11  per-clock cluster count from the counter
- overflow_i  in  1  per-clock overflow flag from the counter, aligned with cnt_i
- start_i  in  1  single-cycle pulse that begins a measurement
- abort_i  in  1  stops any measurement; nothing is published
- continuous_i  in  1  when high, windows repeat back-to-back
- window_len_i  in  16  window length in clocks; 0 is treated as 1
- thresh_hi_i  in  SUM_WIDTH  throttle assert threshold
- thresh_lo_i  in  SUM_WIDTH  throttle deassert threshold
- busy_o  out  1  high in FLUSH or ACCUM
- done_o  out  1  one-cycle pulse when results are published
- sum_o  out  SUM_WIDTH  published window sum
- max_o  out  11  published window maximum of cnt_i
- ovf_cnt_o  out  OVF_WIDTH  published count of overflow_i-high cycles
- throttle_o  out  1  hysteretic throttle flag

Behaviour:
- Reset (synchronous, any state): state to IDLE; all outputs, accumulators and counters to 0.
- States are IDLE, FLUSH and ACCUM. busy_o is registered and high exactly while the state is FLUSH or ACCUM.
- IDLE:
  - start_i=1 and abort_i=0: latch window_len_i (0 becomes 1) into len_q, load the flush counter with PIPE_LATENCY, go to FLUSH.
  - If PIPE_LATENCY=0, go directly to ACCUM.
  - start_i while busy is ignored.
- FLUSH: cnt_i and overflow_i are ignored. Go to ACCUM after exactly PIPE_LATENCY cycles in FLUSH.
- ACCUM: for each of len_q consecutive cycles:
  - sum += cnt_i;
  - max = max(max, cnt_i);
  - ovf += overflow_i, saturating at all-ones.
  - The first ACCUM cycle loads rather than adds, so no clear cycle is needed.
- Last ACCUM cycle (the len_q-th sample):
  - Next cycle, sum_o/max_o/ovf_cnt_o show the totals including that sample, and done_o=1 for one cycle.
  - If continuous_i=1 (sampled on the last cycle), ACCUM continues gaplessly: the next cycle is sample 1 of the new window and len_q is relatched from window_len_i. Otherwise go to IDLE.
- Published outputs hold their values until the next publish or reset.
- abort_i (any state) returns to IDLE on the next cycle: accumulators cleared, no done_o, published outputs and throttle_o unchanged. If abort_i and the last ACCUM sample coincide, abort wins and nothing is published.
- throttle_o is evaluated only at publish, in the same cycle as the new sum_o:
  - set if sum > thresh_hi_i;
  - clear if sum < thresh_lo_i;
  - otherwise hold.
  - If thresh_lo_i > thresh_hi_i, set has priority.
- Arithmetic is unsigned. cnt_i is zero-extended to SUM_WIDTH. The sum cannot wrap for len ≤ 65535.

Test Plan:
- Basic window: reset, then start_i with window_len_i=4 and cnt_i ramp 1,2,3,… from the start cycle.
  - Expect busy_o for 10+4 cycles and done_o one cycle later.
  - Samples taken are the values 11,12,13,14, giving sum_o=50, max_o=14.
- Overflow count: window_len_i=8 with overflow_i high on 3 of the 8 ACCUM cycles -> ovf_cnt_o=3.
  - With window_len_i=65535 and overflow_i held high -> ovf_cnt_o=65535 (saturated).
- Continuous, gapless: continuous_i=1, window_len_i=2, cnt_i constant 5.
  - Expect done_o every 2 cycles, sum_o=10, max_o=5.
  - Change window_len_i to 3 mid-run -> the next window is 3 long, sum_o=15.
- Abort and edge cases:
  - abort_i on the last ACCUM cycle -> no done_o, previous results held, IDLE.
  - start_i with abort_i high -> stays IDLE.
  - window_len_i=0 -> a 1-sample window.
- Throttle hysteresis: thresh_hi=100, thresh_lo=50.
  - Successive window sums of 120, 80, 40, 80 -> throttle_o 1, 1, 0, 0.
- Reset mid-ACCUM: all outputs 0 on the next cycle; a new start_i works normally.
